// File: rtl/fire_control.sv
`default_nettype none
// ============================================================================
// Module   : fire_control
// Purpose  : Trigger sequencer ahead of the ammo counter. It produces single-cycle
//            fire pulses, bursts, cooldown spacing and a timed reload window.
// Option   : FIRE_CONTROL_AUTO_RELOAD_EN enters RELOAD automatically when ammo is 0.
// Revision : 1.0 - initial release
// ============================================================================
module fire_control #(
    parameter int AMMO_W        = 9,
    parameter int CD_W          = 8,
    parameter int BURST_LEN     = 3,
    parameter int RELOAD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        mode,
    input  logic              trigger,
    input  logic              reload_req,
    input  logic              burst_sel,
    input  logic [CD_W-1:0]   cooldown,
    input  logic [AMMO_W-1:0] ammo_level,
    output logic              fire,
    output logic              loading_ammo,
    output logic              dry_fire,
    output logic              busy,
    output logic [1:0]        state,
    output logic [15:0]       shot_count
);

    localparam logic [3:0]        c_MODE_ATTACK = 4'b0010;
    localparam int                c_RL_W        = $clog2(RELOAD_CYCLES + 1);
    localparam logic [c_RL_W-1:0] c_RL_LAST     = c_RL_W'(RELOAD_CYCLES - 1);
    localparam logic [2:0]        c_BURST       = 3'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRE   = 2'd1,
        S_COOL   = 2'd2,
        S_RELOAD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_trig_q;
    logic                r_reload_pend;
    logic [2:0]          r_burst_left;
    logic [CD_W-1:0]     r_cd_timer;
    logic [c_RL_W-1:0]   r_rl_cnt;
    logic                r_fire;
    logic                r_loading;
    logic                r_dry;
    logic                r_busy;
    logic [15:0]         r_shot_count;

    logic                w_pend_nx;
    logic [2:0]          w_burst_nx;
    logic [CD_W-1:0]     w_cd_nx;
    logic [c_RL_W-1:0]   w_rl_nx;
    logic                w_dry;
    logic                w_trig_edge;
    logic                w_atk;
    logic                w_has_ammo;
    logic                w_pend_eff;
    logic                w_auto_rl;

`ifdef FIRE_CONTROL_AUTO_RELOAD_EN
    assign w_auto_rl = 1'b1;
`else
    assign w_auto_rl = 1'b0;
`endif

    assign w_trig_edge = trigger & ~r_trig_q;
    assign w_atk       = (mode == c_MODE_ATTACK);
    assign w_has_ammo  = (ammo_level != '0);
    // A request arriving on the cooldown exit cycle still wins over the burst.
    assign w_pend_eff  = r_reload_pend | reload_req;

    always_comb begin
        w_next     = r_state;
        w_burst_nx = r_burst_left;
        w_cd_nx    = r_cd_timer;
        w_rl_nx    = r_rl_cnt;
        w_pend_nx  = r_reload_pend;
        w_dry      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reload_req) begin
                    w_next = S_RELOAD;
                end else if (w_trig_edge && w_atk && w_has_ammo) begin
                    w_next     = S_FIRE;
                    w_burst_nx = burst_sel ? c_BURST : 3'd1;
                end else begin
                    w_dry = w_trig_edge;
                    if (w_auto_rl && !w_has_ammo) begin
                        w_next = S_RELOAD;
                    end
                end
            end
            S_FIRE: begin
                w_next     = S_COOL;
                w_burst_nx = r_burst_left - 3'd1;
                w_cd_nx    = cooldown;
                w_pend_nx  = w_pend_eff;
            end
            S_COOL: begin
                w_pend_nx = w_pend_eff;
                if (r_cd_timer != '0) begin
                    w_cd_nx = r_cd_timer - CD_W'(1);
                end else if (w_pend_eff) begin
                    w_next     = S_RELOAD;
                    w_burst_nx = 3'd0;
                end else if (r_burst_left != 3'd0 && w_atk && w_has_ammo) begin
                    w_next = S_FIRE;
                end else begin
                    w_burst_nx = 3'd0;
                    w_next     = (w_auto_rl && !w_has_ammo) ? S_RELOAD : S_IDLE;
                end
            end
            S_RELOAD: begin
                w_dry = w_trig_edge;
                if (r_rl_cnt == '0) begin
                    w_next = S_IDLE;
                end else begin
                    w_rl_nx = r_rl_cnt - c_RL_W'(1);
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_next == S_RELOAD && r_state != S_RELOAD) begin
            w_rl_nx   = c_RL_LAST;
            w_pend_nx = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_trig_q      <= 1'b0;
            r_reload_pend <= 1'b0;
            r_burst_left  <= 3'd0;
            r_cd_timer    <= '0;
            r_rl_cnt      <= '0;
            r_fire        <= 1'b0;
            r_loading     <= 1'b0;
            r_dry         <= 1'b0;
            r_busy        <= 1'b0;
            r_shot_count  <= 16'd0;
        end else begin
            r_state       <= w_next;
            r_trig_q      <= trigger;
            r_reload_pend <= w_pend_nx;
            r_burst_left  <= w_burst_nx;
            r_cd_timer    <= w_cd_nx;
            r_rl_cnt      <= w_rl_nx;
            r_fire        <= (w_next == S_FIRE);
            r_loading     <= (w_next == S_RELOAD);
            r_dry         <= w_dry;
            r_busy        <= (w_next != S_IDLE);
            if (w_next == S_FIRE && r_shot_count != 16'hFFFF) begin
                r_shot_count <= r_shot_count + 16'd1;
            end
        end
    end

    assign fire         = r_fire;
    assign loading_ammo = r_loading;
    assign dry_fire     = r_dry;
    assign busy         = r_busy;
    assign state        = r_state;
    assign shot_count   = r_shot_count;

endmodule
`default_nettype wire

// File: tb/tb_fire_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_control
// Purpose  : Scoreboard bench for fire_control. A timeline model predicts the
//            pulses and a monitor checks them against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fire_control;

    localparam int         AMMO_W        = 9;
    localparam int         CD_W          = 8;
    localparam int         BURST_LEN     = 3;
    localparam int         RELOAD_CYCLES = 16;
    localparam logic [3:0] ATK           = 4'b0010;
`ifdef FIRE_CONTROL_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        mode = ATK;
    logic              trigger = 1'b0;
    logic              reload_req = 1'b0;
    logic              burst_sel = 1'b0;
    logic [CD_W-1:0]   cooldown = 8'd3;
    logic [AMMO_W-1:0] ammo_level = 9'd5;
    logic              fire, loading_ammo, dry_fire, busy;
    logic [1:0]        state;
    logic [15:0]       shot_count;

    fire_control #(
        .AMMO_W(AMMO_W), .CD_W(CD_W), .BURST_LEN(BURST_LEN), .RELOAD_CYCLES(RELOAD_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .trigger(trigger), .reload_req(reload_req),
        .burst_sel(burst_sel), .cooldown(cooldown), .ammo_level(ammo_level),
        .fire(fire), .loading_ammo(loading_ammo), .dry_fire(dry_fire), .busy(busy),
        .state(state), .shot_count(shot_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 fire, 1 dry_fire, 2 start of loading window
    typedef struct { int t; int kind; int st; int cnt; } ev_t;
    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // Timeline model: a shot sequence spans [m_fire_at, m_decide_at], a reload ends at m_rl_last.
    int m_rl_last, m_fire_at, m_decide_at, m_left, m_count;
    bit m_pend, m_prev_trig;

    task automatic model_reset();
        m_rl_last   = -1;
        m_fire_at   = -1;
        m_decide_at = -2;
        m_left      = 0;
        m_count     = 0;
        m_pend      = 1'b0;
        m_prev_trig = 1'b0;
        q.delete();
    endtask

    task automatic model_step(input int t);
        bit edge_t, atk, ammo_ok, e_fire, e_dry, e_load;
        edge_t  = trigger && !m_prev_trig;
        atk     = (mode == ATK);
        ammo_ok = (ammo_level != 0);
        e_fire  = 1'b0;
        e_dry   = 1'b0;
        e_load  = 1'b0;
        m_prev_trig = trigger;
        if (t <= m_rl_last) begin
            e_dry = edge_t;
        end else if (t >= m_fire_at && t <= m_decide_at) begin
            m_pend = m_pend | reload_req;
            if (t == m_fire_at) begin
                m_decide_at = t + 1 + int'(cooldown);
            end else if (t == m_decide_at) begin
                if (m_pend) begin
                    m_left = 0;
                    e_load = 1'b1;
                end else if (m_left > 0 && atk && ammo_ok) begin
                    e_fire = 1'b1;
                end else begin
                    m_left = 0;
                    if (AUTO && !ammo_ok) e_load = 1'b1;
                end
            end
        end else begin
            if (reload_req) begin
                e_load = 1'b1;
            end else if (edge_t && atk && ammo_ok) begin
                m_left = burst_sel ? BURST_LEN : 1;
                e_fire = 1'b1;
            end else begin
                e_dry = edge_t;
                if (AUTO && !ammo_ok) e_load = 1'b1;
            end
        end
        if (e_fire) begin
            m_fire_at   = t + 1;
            m_decide_at = t + 1;
            m_left--;
            if (m_count < 65535) m_count++;
            q.push_back('{t + 1, 0, 1, m_count});
        end
        if (e_load) begin
            m_rl_last = t + RELOAD_CYCLES;
            m_pend    = 1'b0;
        end
        if (e_dry)  q.push_back('{t + 1, 1, (t + 1 <= m_rl_last) ? 3 : 0, 0});
        if (e_load) q.push_back('{t + 1, 2, 3, 0});
    endtask

    task automatic drive(input int n, input bit trg, input bit rl, input bit bs,
                         input logic [3:0] md, input int cd, input int am);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            trigger    = trg;
            reload_req = rl;
            burst_sel  = bs;
            mode       = md;
            cooldown   = CD_W'(cd);
            ammo_level = AMMO_W'(am);
            model_step(cyc);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        trigger    = 1'b0;
        reload_req = 1'b0;
        burst_sel  = 1'b0;
        mode       = ATK;
        cooldown   = 8'd3;
        ammo_level = 9'd5;
        model_reset();
        model_step(cyc);
    endtask

    task automatic check_zero_outputs(input string nm);
        check(fire == 1'b0,         {nm, "_fire"}, int'(fire), 0);
        check(loading_ammo == 1'b0, {nm, "_loading"}, int'(loading_ammo), 0);
        check(dry_fire == 1'b0,     {nm, "_dry"}, int'(dry_fire), 0);
        check(busy == 1'b0,         {nm, "_busy"}, int'(busy), 0);
        check(state == 2'd0,        {nm, "_state"}, int'(state), 0);
        check(shot_count == 16'd0,  {nm, "_shot_count"}, int'(shot_count), 0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic expect_ev(input int kind, input string nm);
        ev_t e;
        checks++;
        if (q.size() == 0 || q[0].t != cyc || q[0].kind != kind) begin
            errors++;
            $display("FAIL %s unexpected pulse cycle=%0d actual=1 expected=0", nm, cyc);
        end else begin
            e = q.pop_front();
            check(int'(state) == e.st, {nm, "_state"}, int'(state), e.st);
            check(busy == (e.st != 0), {nm, "_busy"}, int'(busy), int'(e.st != 0));
            if (kind == 0) check(int'(shot_count) == e.cnt, "shot_count", int'(shot_count), e.cnt);
        end
    endtask

    // Monitor: consumes predicted events as the DUT presents pulses.
    initial begin
        int run;
        bit prev_load;
        run = 0;
        prev_load = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                run = 0;
                prev_load = 1'b0;
                continue;
            end
            while (q.size() > 0 && q[0].t < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event kind=%0d actual=absent expected_cycle=%0d", q[0].kind, q[0].t);
                void'(q.pop_front());
            end
            if (fire) begin
                expect_ev(0, "fire");
                check(!loading_ammo && !dry_fire, "fire_exclusive", int'({loading_ammo, dry_fire}), 0);
            end
            if (dry_fire) expect_ev(1, "dry_fire");
            if (loading_ammo && !prev_load) expect_ev(2, "load_start");
            if (loading_ammo) begin
                run++;
            end else if (prev_load) begin
                check(run == RELOAD_CYCLES, "load_len", run, RELOAD_CYCLES);
                run = 0;
            end
            prev_load = loading_ammo;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        release_reset();
        mon_en = 1'b1;

        // single shot with held trigger
        drive(10, 1, 0, 0, ATK, 3, 5);
        drive(10, 0, 0, 0, ATK, 3, 5);
        // burst, then burst aborted by empty magazine
        drive(1, 1, 0, 1, ATK, 2, 9);
        drive(20, 0, 0, 1, ATK, 2, 9);
        drive(1, 1, 0, 1, ATK, 2, 9);
        drive(15, 0, 0, 1, ATK, 2, 0);
        drive(20, 0, 0, 0, ATK, 2, 9);
        // wrong mode and empty magazine
        drive(1, 1, 0, 0, 4'b0001, 2, 9);
        drive(2, 0, 0, 0, ATK, 2, 9);
        drive(1, 1, 0, 0, ATK, 2, 0);
        drive(20, 0, 0, 0, ATK, 2, 5);
        // reload beats trigger, trigger during reload, reload requested in cooldown
        drive(1, 1, 1, 0, ATK, 2, 5);
        drive(3, 0, 0, 0, ATK, 2, 5);
        drive(1, 1, 0, 0, ATK, 2, 5);
        drive(20, 0, 0, 0, ATK, 2, 5);
        drive(1, 1, 0, 0, ATK, 6, 5);
        drive(3, 0, 0, 0, ATK, 6, 5);
        drive(1, 0, 1, 0, ATK, 6, 5);
        drive(30, 0, 0, 0, ATK, 6, 5);
        // reset in the middle of a burst
        drive(1, 1, 0, 1, ATK, 4, 9);
        drive(3, 0, 0, 1, ATK, 4, 9);
        mid_reset();
        drive(20, 0, 0, 1, ATK, 4, 9);
        // auto-reload check point: empty magazine while idle
        drive(25, 0, 0, 0, ATK, 2, 0);
        drive(5, 0, 0, 0, ATK, 2, 5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit trg, rl, bs;
            logic [3:0] md;
            int cd, am;
            trg = ($urandom_range(0, 9) < 3) ? ~trigger : trigger;
            rl  = ($urandom_range(0, 99) < 3);
            bs  = $urandom_range(0, 1);
            md  = ($urandom_range(0, 99) < 85) ? ATK : 4'($urandom_range(0, 15));
            cd  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 20);
            am  = ($urandom_range(0, 99) < 15) ? 0 : $urandom_range(1, 300);
            if (i % 1000 == 999) mid_reset();
            else drive(1, trg, rl, bs, md, cd, am);
        end

        drive(60, 0, 0, 0, ATK, 3, 5);
        check(q.size() == 0, "queue_drained", q.size(), 0);
        @(negedge clk);
        check(state == 2'd0, "final_state", int'(state), 0);
        check(int'(shot_count) == m_count, "final_shot_count", int'(shot_count), m_count);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fire_control.md
Name: fire_control

Overview:
Trigger-sequencing stage directly upstream of the weapons/ammo counter block. Converts the raw pilot trigger and reload button into clean single-cycle `fire` pulses and a timed `loading_ammo` window. It enforces attack-mode gating, inter-shot cooldown and optional 3-round bursts. It takes the counter's ammo level back as feedback so it never issues a shot into an empty magazine.

Parameters:
AMMO_W, 9, width of ammo level bus (matches ammo counter)
CD_W, 8, width of cooldown count
BURST_LEN, 3, shots per burst when burst_sel=1 (1..7)
RELOAD_CYCLES, 16, cycles loading_ammo is held high per reload (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active low
mode  in  4  ship mode; 4'b0010 = attack
trigger  in  1  raw trigger level, synchronous to clk
reload_req  in  1  reload button level
burst_sel  in  1  0 = single shot, 1 = burst of BURST_LEN
cooldown  in  CD_W  cycles between shots; sampled at each FIRE
ammo_level  in  AMMO_W  current ammo from downstream counter
fire  out  1  one-cycle shot pulse to counter
loading_ammo  out  1  high for RELOAD_CYCLES during reload
dry_fire  out  1  one-cycle pulse on a rejected trigger
busy  out  1  state != IDLE
state  out  2  IDLE=0, FIRE=1, COOL=2, RELOAD=3
shot_count  out  16  saturating count of fire pulses

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, fire=0, loading_ammo=0, dry_fire=0, shot_count=0, burst_left=0, cd_timer=0, trig_q=0, reload_pend=0. All outputs are registered.
- Trigger edge: `trig_edge = trigger & ~trig_q`, where trig_q is the trigger level registered every cycle. A held trigger fires only once per press.
- `atk = (mode == 4'b0010)`.
- IDLE:
  - reload_req=1 → RELOAD. Reload has priority over trigger in the same cycle.
  - Else trig_edge & atk & ammo_level != 0 → FIRE, with burst_left = burst_sel ? BURST_LEN : 1.
  - Else trig_edge & (~atk | ammo_level == 0) → dry_fire=1 for 1 cycle; stay IDLE.
- FIRE (1 cycle):
  - fire=1.
  - shot_count += 1, saturating at 16'hFFFF.
  - burst_left -= 1.
  - cd_timer = cooldown.
  - Next state COOL.
- COOL:
  - cd_timer decrements each cycle. Exit on the cycle cd_timer == 0; cooldown=0 spends exactly 1 cycle in COOL.
  - Exit priority:
    1. reload_pend → RELOAD, with burst_left cleared.
    2. burst_left != 0 & atk & ammo_level != 0 → FIRE.
    3. Otherwise → IDLE, with burst_left cleared.
  - Mode leaving attack or ammo reaching 0 mid-burst aborts the remaining shots.
- Reload request outside IDLE: reload_req=1 in FIRE or COOL sets reload_pend. reload_pend clears on entry to RELOAD.
- Triggers while busy:
  - Ignored in FIRE and COOL; no dry_fire.
  - In RELOAD, trig_edge produces dry_fire=1.
- RELOAD:
  - loading_ammo=1 for exactly RELOAD_CYCLES consecutive cycles, counted by an internal counter; then → IDLE.
  - reload_req during RELOAD is ignored.
  - fire is never high while loading_ammo is high.
- Shot spacing: minimum spacing between fire pulses is cooldown+2 cycles.
- Invariants:
  - fire=1 only when atk=1 and ammo_level != 0 at the decision cycle.
  - fire and dry_fire are never high together.
- Reset mid-operation: any state returns to IDLE immediately. Pending burst, reload and timers are discarded; outputs drop asynchronously.

Optional Feature:
Macro FIRE_CONTROL_AUTO_RELOAD_EN.
- Defined: in IDLE, or on COOL exit, when ammo_level == 0 and reload_req=0, the FSM enters RELOAD automatically. dry_fire is still pulsed for a trigger edge in that cycle.
- Undefined: no automatic reload. An empty magazine stays empty until reload_req is asserted.

Test Plan:
1. Single shot: mode=0010, ammo_level=5, cooldown=3, burst_sel=0, trigger held high 10 cycles → exactly one fire pulse, COOL for 4 cycles, back to IDLE, shot_count=1.
2. Burst: burst_sel=1, cooldown=2, ammo_level=9, one trigger edge → 3 fire pulses spaced 4 cycles apart, shot_count=3. Repeat with ammo_level driven to 0 after the first shot → only 1 pulse.
3. Wrong mode / empty: mode=0001 with trigger edge → dry_fire=1 for 1 cycle, fire=0. Then mode=0010, ammo_level=0 with trigger edge → dry_fire=1, fire=0.
4. Reload: reload_req and trig_edge in the same IDLE cycle → RELOAD, loading_ammo=1 for 16 cycles, no fire. A trigger edge during RELOAD → dry_fire=1. reload_req during COOL → RELOAD begins immediately after cooldown expires.
5. Reset mid-burst: rst_n low during COOL of a 3-round burst → outputs 0 and state=IDLE asynchronously. After release, no residual shots.
6. FIRE_CONTROL_AUTO_RELOAD_EN defined: ammo_level=0 in IDLE, no reload_req → RELOAD entered next cycle, loading_ammo high 16 cycles.
